// File: rtl/paridade_pkg.sv
// Shared constants and types for the streaming parity block.
// Packet tracking state and parity-mode encodings.
package paridade_pkg;

  localparam logic PAR_PAR   = 1'b0;
  localparam logic PAR_IMPAR = 1'b1;

  typedef enum logic {
    E_OCIOSO,
    E_PACOTE
  } estado_t;

endpackage

// File: rtl/paridade_stream_if.sv
// Valid/ready stream bundle for paridade_stream:
// input word side plus registered parity result side.
interface paridade_stream_if #(
  parameter int LARGURA = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [LARGURA-1:0] in_data;
  logic               in_par;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [LARGURA-1:0] out_data;
  logic               out_par;
  logic               out_erro;
  logic               out_last;
  logic               out_par_pacote;

  modport master (
    output in_valid,
    output in_data,
    output in_par,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_par,
    input  out_erro,
    input  out_last,
    input  out_par_pacote
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_par,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_par,
    output out_erro,
    output out_last,
    output out_par_pacote
  );

endinterface

// File: rtl/paridade_n_bits.sv
// Combinational XOR reduction of a LARGURA-bit word.
// Result is 1 when the word holds an odd count of ones.
module paridade_n_bits #(
  parameter int LARGURA = 8
) (
  input  logic [LARGURA-1:0] i_dado,
  output logic               o_par
);

  assign o_par = ^i_dado;

endmodule

// File: rtl/paridade_stream.sv
// Streaming parity generator/checker with packet parity,
// saturating error counter and a single output register.
module paridade_stream
  import paridade_pkg::*;
#(
  parameter int LARGURA = 8,
  parameter int CONT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              impar,
  input  logic              cnt_clr,
  output logic [CONT_W-1:0] erro_cnt,
  paridade_stream_if.slave  bus
);

  localparam logic [CONT_W-1:0] CNT_MAX = '1;

  estado_t            r_estado;
  estado_t            w_estado_nxt;
  logic               r_impar;
  logic               r_acc;
  logic               r_valid;
  logic [LARGURA-1:0] r_data;
  logic               r_par;
  logic               r_erro;
  logic               r_last;
  logic               r_par_pac;
  logic [CONT_W-1:0]  r_cnt;

  logic w_xor;
  logic w_ready;
  logic w_accept;
  logic w_impar_eff;
  logic w_par;
  logic w_erro;
  logic w_acc_nxt;

  paridade_n_bits #(
    .LARGURA (LARGURA)
  ) u_xor (
    .i_dado (bus.in_data),
    .o_par  (w_xor)
  );

  assign w_ready  = !r_valid || bus.out_ready;
  assign w_accept = bus.in_valid && w_ready;

  // Mode is frozen for the rest of the packet once the first beat is taken.
  assign w_impar_eff = (r_estado == E_PACOTE) ? r_impar : impar;
  assign w_par       = w_xor ^ w_impar_eff;
  assign w_erro      = bus.in_par ^ w_par;
  assign w_acc_nxt   = r_acc ^ w_xor;

  always_comb begin
    w_estado_nxt = r_estado;
    if (w_accept) begin
      w_estado_nxt = bus.in_last ? E_OCIOSO : E_PACOTE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= E_OCIOSO;
    end else begin
      r_estado <= w_estado_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_impar <= PAR_PAR;
      r_acc   <= 1'b0;
    end else if (w_accept) begin
      r_impar <= w_impar_eff;
      r_acc   <= bus.in_last ? 1'b0 : w_acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_par     <= 1'b0;
      r_erro    <= 1'b0;
      r_last    <= 1'b0;
      r_par_pac <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_data    <= bus.in_data;
      r_par     <= w_par;
      r_erro    <= w_erro;
      r_last    <= bus.in_last;
      r_par_pac <= bus.in_last ? (w_acc_nxt ^ w_impar_eff) : 1'b0;
    end else if (bus.out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_accept && w_erro && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.in_ready       = w_ready;
  assign bus.out_valid      = r_valid;
  assign bus.out_data       = r_data;
  assign bus.out_par        = r_par;
  assign bus.out_erro       = r_erro;
  assign bus.out_last       = r_last;
  assign bus.out_par_pacote = r_par_pac;
  assign erro_cnt           = r_cnt;

endmodule

// File: tb/tb_paridade_stream.sv
// Directed bench for paridade_stream: scoreboard queue filled by
// the stimulus, drained by a monitor on each output transfer.
module tb_paridade_stream;

  localparam int LARGURA = 8;
  localparam int CONT_W  = 2;

  typedef struct packed {
    logic [LARGURA-1:0] data;
    logic               par;
    logic               erro;
    logic               last;
    logic               pp;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              impar;
  logic              cnt_clr;
  logic [CONT_W-1:0] erro_cnt;

  int n_chk;
  int n_err;
  exp_t q[$];

  paridade_stream_if #(.LARGURA(LARGURA)) bus ();

  paridade_stream #(
    .LARGURA (LARGURA),
    .CONT_W  (CONT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .impar    (impar),
    .cnt_clr  (cnt_clr),
    .erro_cnt (erro_cnt),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nome, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nome, act, req);
    end
  endtask

  // Monitor: a transfer is decided by values stable across the negedge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_out: got data %0h, expected none",
                 bus.out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.data));
        chk("out_par", 32'(bus.out_par), 32'(e.par));
        chk("out_erro", 32'(bus.out_erro), 32'(e.erro));
        chk("out_last", 32'(bus.out_last), 32'(e.last));
        chk("out_par_pacote", 32'(bus.out_par_pacote), 32'(e.pp));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send(input logic [7:0] d, input logic p, input logic l,
                      input logic m, input logic ep, input logic ee,
                      input logic epp);
    logic ok;
    exp_t e;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_par   = p;
    bus.in_last  = l;
    impar        = m;
    e = '{data: d, par: ep, erro: ee, last: l, pp: epp};
    q.push_back(e);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: got in_ready 0, expected 1");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    impar         = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_par    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    tick(2);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_erro_cnt", 32'(erro_cnt), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;
    tick(1);

    // 1: even mode, A5 has four ones
    send(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_cnt", 32'(erro_cnt), 0);

    // 2: odd mode, 07 has three ones, in_par wrong
    send(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t2_cnt", 32'(erro_cnt), 1);
    tick(2);

    // 3: backpressure
    bus.out_ready = 1'b0;
    send(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_in_ready_low", 32'(bus.in_ready), 0);
    tick(3);
    chk("t3_hold_valid", 32'(bus.out_valid), 1);
    chk("t3_hold_data", 32'(bus.out_data), 32'h11);
    fork
      send(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
        tick(3);
        bus.out_ready = 1'b1;
      end
    join
    tick(2);
    chk("t3_drained", 32'(q.size()), 0);

    // 4: mode latched on first beat of a packet
    send(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t4_cnt", 32'(erro_cnt), 1);

    // 5: saturation with a 2-bit counter
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("t5_clr", 32'(erro_cnt), 0);
    send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_cnt1", 32'(erro_cnt), 1);
    send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_cnt2", 32'(erro_cnt), 2);
    send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_cnt3", 32'(erro_cnt), 3);
    send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_cnt_sat", 32'(erro_cnt), 3);
    cnt_clr = 1'b1;
    send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cnt_clr = 1'b0;
    chk("t5_clr_wins", 32'(erro_cnt), 0);
    tick(2);

    // 6: async reset mid-packet
    bus.out_ready = 1'b0;
    send(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_cnt_pre", 32'(erro_cnt), 1);
    chk("t6_valid_pre", 32'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus.out_valid), 0);
    chk("t6_async_cnt", 32'(erro_cnt), 0);
    void'(q.pop_back());
    tick(1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick(1);
    send(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
    chk("final_queue_empty", 32'(q.size()), 0);
    tick(1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/paridade_stream.md
Name: paridade_stream

Overview:
- Parametrised streaming parity generator/checker, successor to the fixed 4-bit combinational even-parity generator.
- Accepts LARGURA-bit words on a valid/ready interface.
- Per word: computes even or odd parity, checks it against a received parity bit, and counts mismatches in a saturating counter.
- Per packet (framed by in_last): accumulates a packet-level parity bit.
- Sits between a data source and a link/transmit stage; one registered output stage.

Parameters:
- LARGURA, 8, data word width (>=2).
- CONT_W, 8, error counter width (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- impar  in  1  parity mode: 0 = even, 1 = odd; sampled per packet.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  LARGURA  input word.
- in_par  in  1  received parity bit to check against.
- in_last  in  1  final word of packet.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LARGURA  registered copy of in_data.
- out_par  out  1  generated word parity.
- out_erro  out  1  in_par != generated parity for this word.
- out_last  out  1  registered in_last.
- out_par_pacote  out  1  packet parity; meaningful only when out_last=1, else 0.
- cnt_clr  in  1  synchronous clear of erro_cnt.
- erro_cnt  out  CONT_W  saturating count of accepted errored words.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_par=0, out_erro=0, out_last=0, out_par_pacote=0, erro_cnt=0, packet accumulator=0, mode latch=0, in-packet flag=0.
- Reset mid-packet: the packet is discarded. The first beat after reset starts a new packet.
- Handshake:
  - Accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational pass-through, single output register).
  - No word is lost or duplicated.
  - Output fields are stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from accept to out_valid. Full throughput of 1 word/cycle when out_ready=1.
- out_valid update: set on accept. Cleared on a transfer with no accept in the same cycle. Stays 1 on a simultaneous transfer and accept.
- Mode sampling:
  - impar is sampled on the first beat of each packet (accept while in-packet flag=0) and held as impar_eff until the beat with in_last=1.
  - Changes to impar mid-packet are ignored.
  - A single-beat packet (in_last on the first beat) uses impar directly.
- Word parity: out_par = (XOR-reduce in_data) XOR impar_eff. With impar_eff=0, data plus parity holds an even count of ones; with 1, an odd count.
- Check: out_erro = in_par XOR out_par.
- Packet accumulator:
  - acc_next = acc XOR (XOR-reduce in_data) on each accept.
  - On an accept with in_last=1: out_par_pacote = acc_next XOR impar_eff, then acc and the in-packet flag clear.
  - The next accept starts a fresh packet.
- erro_cnt:
  - +1 on each accept whose computed error is 1.
  - Saturates at 2^CONT_W-1 (no wrap).
  - cnt_clr=1 sets it to 0; a clear beats a simultaneous increment.
- The counter updates at accept time, the same edge as the output register load.

Decomposition:
- Shared package/include paridade_pkg: constants PAR_PAR=1'b0 and PAR_IMPAR=1'b1.
- One natural sub-module: paridade_n_bits (parameter LARGURA), a combinational XOR-reduction tree, instantiated once for in_data.
- The handshake register, mode latch, accumulator and counter stay in the top.

Test Plan (LARGURA=8 unless stated):
1. impar=0, in_data=8'hA5, in_par=0, out_ready=1 → next cycle out_valid=1, out_data=8'hA5, out_par=0, out_erro=0; erro_cnt stays 0.
2. impar=1, in_data=8'h07, in_par=1 → out_par=0, out_erro=1; erro_cnt 0→1 on the accept edge.
3. out_ready=0, send 8'h11 then 8'h22 → in_ready drops after the first accept; out_data holds 8'h11. Raise out_ready → 8'h11 then 8'h22 delivered once each, in order.
4. Packet 8'h01, 8'h03, 8'h00 (in_last on the third), impar=0 on beat 1, impar=1 on beats 2–3 → all beats use even parity; third output has out_last=1, out_par_pacote=1. Next single-beat packet 8'h00 with impar=1 → out_par_pacote=1.
5. CONT_W=2, four consecutive errored beats → erro_cnt 1,2,3,3. Then cnt_clr=1 together with an errored accept → erro_cnt=0.
6. rst_n low while out_valid=1 mid-packet (acc=1) → out_valid=0 and erro_cnt=0 immediately, without waiting for clk. After release, a packet 8'h00 with in_last, impar=0 → out_par_pacote=0.
